// File: rtl/distlaw_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// distlaw_sweep_ctrl
//
// Purpose: clocked exhaustive-sweep checker for two combinational networks
// that are expected to be logically equivalent (e.g. a&(b|c) vs (a&b)|(a&c)).
// Each input vector 0 .. 2^N_IN-1 is driven on vec, held for SETTLE_CYC
// cycles, then the two network outputs are compared for one cycle.
// Mismatches are counted and the first failing vector is captured.
//
// Parameters:
//   N_IN       - number of network inputs (sweep covers 2^N_IN vectors)
//   SETTLE_CYC - cycles each vector is held before sampling (0..15)
//
// Optional build macro:
//   STOP_ON_FAIL_EN - when defined, the first mismatch ends the sweep
//                     (done pulses, pass=0, vec holds the failing vector).
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   one-cycle request to begin a sweep (ignored if busy)
//   abort          in   stop a running sweep, return to IDLE without done
//   vec            out  vector driven to both networks (MSB = a)
//   lhs            in   output of network A
//   rhs            in   output of network B
//   busy           out  high while a sweep is running
//   done           out  one-cycle pulse when a sweep completes
//   pass           out  1 if the completed sweep found no mismatch
//   mismatch_cnt   out  number of mismatching vectors (never wraps)
//   fail_valid     out  a failing vector has been captured
//   first_fail_vec out  first vector on which lhs != rhs
// ---------------------------------------------------------------------------
module distlaw_sweep_ctrl #(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec,
    input  logic            lhs,
    input  logic            rhs,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_cnt,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam logic [N_IN-1:0] VEC_LAST    = '1;
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYC);
    // With no settle window a vector goes straight from IDLE/SAMPLE to SAMPLE.
    localparam bit              NO_SETTLE   = (SETTLE_CYC == 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_settle;
    logic            w_mis;
    logic            w_sample;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic [N_IN:0]   w_cnt_nxt;

    assign w_mis = lhs ^ rhs;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = NO_SETTLE ? S_SAMPLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)              w_state_nxt = S_IDLE;
                else if (r_settle <= 4'd1) w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
`ifdef STOP_ON_FAIL_EN
                end else if (w_mis) begin
                    w_state_nxt = S_DONE;
`endif
                end else if (vec == VEC_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = NO_SETTLE ? S_SAMPLE : S_SETTLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        // abort outranks the compare, so an aborted SAMPLE is never counted.
        w_sample   = (r_state == S_SAMPLE) && !abort;
        w_busy_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_cnt_nxt  = mismatch_cnt;
        if (w_sample && w_mis) w_cnt_nxt = mismatch_cnt + (N_IN+1)'(1);
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec            <= '0;
            r_settle       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            busy <= w_busy_nxt;
            done <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        vec            <= '0;
                        r_settle       <= SETTLE_LOAD;
                        pass           <= 1'b0;
                        mismatch_cnt   <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_vec <= '0;
                    end
                end
                S_SETTLE: begin
                    if (abort) pass <= 1'b0;
                    else       r_settle <= r_settle - 4'd1;
                end
                S_SAMPLE: begin
                    if (abort) begin
                        pass <= 1'b0;
                    end else begin
                        mismatch_cnt <= w_cnt_nxt;
                        if (w_mis && !fail_valid) begin
                            first_fail_vec <= vec;
                            fail_valid     <= 1'b1;
                        end
                        // Pass uses the count including this final sample.
                        if (w_state_nxt == S_DONE) begin
                            pass <= (w_cnt_nxt == '0);
                        end else begin
                            vec      <= vec + N_IN'(1);
                            r_settle <= SETTLE_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_distlaw_sweep_ctrl.sv
module tb_distlaw_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] rtab = 8'hE0;

    // DUT 0: default parameters, rhs taken from a truth table chosen per test
    logic [2:0] vec0;
    logic       lhs0, rhs0, busy0, done0, pass0, fv0;
    logic [3:0] cnt0;
    logic [2:0] ff0;

    // DUT 1: SETTLE_CYC = 0, inverted network rhs = ~lhs
    logic [2:0] vec1;
    logic       lhs1, rhs1, busy1, done1, pass1, fv1;
    logic [3:0] cnt1;
    logic [2:0] ff1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic net_a(input logic [2:0] v);
        return v[2] & (v[1] | v[0]);
    endfunction

    assign lhs0 = net_a(vec0);
    assign rhs0 = rtab[vec0];
    assign lhs1 = net_a(vec1);
    assign rhs1 = ~lhs1;

    distlaw_sweep_ctrl #(.N_IN(3), .SETTLE_CYC(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec(vec0), .lhs(lhs0), .rhs(rhs0), .busy(busy0), .done(done0),
        .pass(pass0), .mismatch_cnt(cnt0), .fail_valid(fv0), .first_fail_vec(ff0)
    );

    distlaw_sweep_ctrl #(.N_IN(3), .SETTLE_CYC(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec(vec1), .lhs(lhs1), .rhs(rhs1), .busy(busy1), .done(done1),
        .pass(pass1), .mismatch_cnt(cnt1), .fail_valid(fv1), .first_fail_vec(ff1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] tab;
        int         cnt;
        int         ff;
        int         fv;
        int         pass;
        int         busy_len;
        int         last_vec;
    } vec_t;

    // Reference: compare the two truth tables vector by vector.
    function automatic vec_t model(input logic [7:0] tab, input int settle);
        vec_t r;
        int   nmis = 0;
        int   first = -1;
        for (int v = 0; v < 8; v++) begin
            if (net_a(3'(v)) != tab[v]) begin
                nmis++;
                if (first < 0) first = v;
            end
        end
        r.tab = tab;
        r.fv  = (nmis > 0);
        r.ff  = (first < 0) ? 0 : first;
        r.pass = (nmis == 0);
`ifdef STOP_ON_FAIL_EN
        r.cnt      = (nmis > 0) ? 1 : 0;
        r.busy_len = ((nmis > 0) ? first + 1 : 8) * (settle + 1);
        r.last_vec = (nmis > 0) ? first : 7;
`else
        r.cnt      = nmis;
        r.busy_len = 8 * (settle + 1);
        r.last_vec = 7;
`endif
        return r;
    endfunction

    // Run one sweep on DUT0 (and DUT1 in parallel) over a fixed window.
    task automatic run_sweep(input vec_t e, input bit chk1, input string tag);
        int busy_c = 0, done_c = 0, vec_bad = 0, overlap = 0;
        int busy1_c = 0, done1_c = 0;
        vec_t e1;
        rtab = e.tab;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy0) begin
                if (int'(vec0) != busy_c / 3) vec_bad++;
                busy_c++;
            end
            if (done0) begin
                done_c++;
                if (busy0) overlap++;
            end
            if (busy1) busy1_c++;
            if (done1) done1_c++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, busy_c, e.busy_len);
        check({tag, "_vec_steps_bad"}, vec_bad, 0);
        check({tag, "_done_pulses"}, done_c, 1);
        check({tag, "_done_busy_overlap"}, overlap, 0);
        check({tag, "_mismatch_cnt"}, cnt0, e.cnt);
        check({tag, "_fail_valid"}, fv0, e.fv);
        check({tag, "_first_fail_vec"}, ff0, e.ff);
        check({tag, "_pass"}, pass0, e.pass);
        check({tag, "_last_vec"}, vec0, e.last_vec);
        if (chk1) begin
            e1 = model(8'h1F, 0);  // ~lhs table: every vector mismatches
            check("s0_busy_len", busy1_c, e1.busy_len);
            check("s0_done_pulses", done1_c, 1);
            check("s0_mismatch_cnt", cnt1, e1.cnt);
            check("s0_fail_valid", fv1, 1);
            check("s0_first_fail_vec", ff1, 0);
            check("s0_pass", pass1, 0);
        end
    endtask

    vec_t tbl[8];

    initial begin
        // Fixed rows with hand-derived expectations, then random tables.
        tbl[0] = '{8'hE0, 0, 0, 0, 1, 24, 7};          // correct network
`ifdef STOP_ON_FAIL_EN
        tbl[1] = '{8'hEA, 1, 1, 1, 0, 6, 1};           // (a&b)|c
        tbl[2] = '{8'h00, 1, 5, 1, 0, 18, 5};
        tbl[3] = '{8'hFF, 1, 0, 1, 0, 3, 0};
`else
        tbl[1] = '{8'hEA, 2, 1, 1, 0, 24, 7};
        tbl[2] = '{8'h00, 3, 5, 1, 0, 24, 7};
        tbl[3] = '{8'hFF, 5, 0, 1, 0, 24, 7};
`endif
        for (int i = 4; i < 8; i++) tbl[i] = model(8'($urandom), 2);

        // Reset state
        #12;
        check("rst_vec", vec0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_fv", fv0, 0);
        check("rst_ff", ff0, 0);
        @(negedge clk); rst = 1'b0;

        run_sweep(tbl[0], 1'b1, "correct");
        for (int i = 1; i < 8; i++) run_sweep(tbl[i], 1'b0, $sformatf("row%0d", i));

        // Async reset in the middle of a sweep
        rtab = 8'hE0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 60 && vec0 != 3'd3; k++) @(negedge clk);
        check("wait_vec3", vec0, 3);
        check("mid_busy", busy0, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_vec", vec0, 0);
        check("arst_busy", busy0, 0);
        check("arst_cnt", cnt0, 0);
        check("arst_fv", fv0, 0);
        @(negedge clk); rst = 1'b0;
        run_sweep(tbl[0], 1'b0, "after_rst");

        // Busy guards: start at vec=4 ignored, abort at vec=5
        rtab = 8'hE0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 60 && vec0 != 3'd4; k++) @(negedge clk);
        check("wait_vec4", vec0, 4);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_ignored_vec", vec0, 4);
        check("start_ignored_busy", busy0, 1);
        for (int k = 0; k < 60 && vec0 != 3'd5; k++) @(negedge clk);
        check("wait_vec5", vec0, 5);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort_busy", busy0, 0);
        check("abort_vec", vec0, 5);
        check("abort_done", done0, 0);
        check("abort_pass", pass0, 0);
        check("abort_cnt", cnt0, 0);
        begin
            int dc = 0;
            for (int k = 0; k < 6; k++) begin
                if (done0) dc++;
                @(negedge clk);
            end
            check("abort_no_done", dc, 0);
        end
        check("abort_idle_vec_hold", vec0, 5);

        // Abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("idle_abort_busy", busy0, 0);
        check("idle_abort_vec", vec0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/distlaw_sweep_ctrl.md
Name: distlaw_sweep_ctrl

Overview:
- Sequencer that drives an exhaustive input sweep into two gate-level networks that should be equivalent, such as a&(b|c) and (a&b)|(a&c).
- Holds each input vector for a settle window, then samples and compares the two network outputs.
- Counts mismatches and records the first failing vector.
- Replaces the hand-written #20 initial-block stimulus with a clocked, reusable checker that sits beside the gate netlists.

Parameters:
- N_IN, 3: number of network inputs; sweep covers vectors 0 .. 2^N_IN-1.
- SETTLE_CYC, 2: clock cycles each vector is held before sampling; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep.
- abort  in  1  stop the sweep and return to IDLE.
- vec  out  N_IN  input vector driven to both networks; bit N_IN-1 = a, and so on down.
- lhs  in  1  output of network A (e.g. w4).
- rhs  in  1  output of network B (e.g. w5).
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  sweep result: 1 if no mismatch was found.
- mismatch_cnt  out  N_IN+1  number of mismatching vectors in the last sweep.
- fail_valid  out  1  a failing vector has been captured.
- first_fail_vec  out  N_IN  first vector on which lhs != rhs.

Behaviour:
- Reset (async, active-high): state=IDLE; vec, busy, done, pass, mismatch_cnt, fail_valid, first_fail_vec all 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1 at an edge: clear mismatch_cnt, fail_valid, first_fail_vec and pass.
  - Set vec=0, load settle counter with SETTLE_CYC, go to SETTLE (or straight to SAMPLE if SETTLE_CYC=0).
  - busy=1 from the next cycle.
- SETTLE:
  - Decrement the settle counter each cycle; vec is held stable.
  - When the counter reaches 1, go to SAMPLE.
- SAMPLE (one cycle): compare lhs with rhs.
  - On mismatch: mismatch_cnt += 1.
  - On the first mismatch only: first_fail_vec=vec and fail_valid=1.
  - If vec == 2^N_IN-1, go to DONE.
  - Otherwise vec += 1, reload the settle counter and go to SETTLE (or stay in SAMPLE if SETTLE_CYC=0).
- DONE (one cycle): done=1, busy=0, pass=(mismatch_cnt==0); go to IDLE. vec is kept at its last value.
- Timing: each vector takes SETTLE_CYC+1 cycles, so busy stays high for exactly 2^N_IN*(SETTLE_CYC+1) cycles. Default is 24 cycles.
- Result outputs (pass, mismatch_cnt, fail_valid, first_fail_vec) hold until the next accepted start.
- start while busy: ignored, no restart.
- start in the DONE cycle: ignored.
- abort while busy:
  - Next state is IDLE; busy=0, no done pulse, pass=0.
  - mismatch_cnt keeps its partial count.
  - abort has priority over a SAMPLE compare in the same cycle; that compare is not counted.
- abort in IDLE: no effect.
- mismatch_cnt must not wrap; the width N_IN+1 holds the maximum count 2^N_IN.
- All outputs are registered.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- When defined, the first mismatch ends the sweep:
  - From SAMPLE go to DONE.
  - done pulses, pass=0, mismatch_cnt=1.
  - vec holds the failing vector.
- When undefined, the sweep always covers all 2^N_IN vectors.

Test Plan:
- Reset mid-sweep: assert rst asynchronously at vec=3 -> all outputs 0 immediately; a later start runs a full 24-cycle sweep.
- Correct networks (lhs=a&(b|c), rhs=(a&b)|(a&c)), default parameters, start pulse -> vec steps 0..7 with 3 cycles per vector; busy high for 24 cycles; done pulses once; pass=1, mismatch_cnt=0, fail_valid=0.
- Faulty rhs=(a&b)|c -> mismatches at vectors 1 and 3; mismatch_cnt=2, first_fail_vec=3'b001, pass=0.
- Busy guards: start asserted at vec=4 is ignored; abort at vec=5 -> busy low next cycle, no done, pass=0, vec stays 5.
- SETTLE_CYC=0 -> one cycle per vector, busy high 8 cycles; with the inverted network rhs=~lhs, mismatch_cnt=8 (4'b1000).
- STOP_ON_FAIL_EN defined, faulty network from the third scenario -> done pulses after the vector-1 sample; vec=1, mismatch_cnt=1, pass=0.
